// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch/decode constants: bubble word, reset PC, fetch state encoding
// and RV32 major opcodes.
package instruction_fetch_unit_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter register: redirect/pending load has priority over
// sequential increment; async active-low reset.
module ifu_pc_reg
    import instruction_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        inc,
    input  logic [31:0] load_value,
    output logic [31:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32IM fetch stage: PC, imem handshake, stall hold and redirect drain.
// Define IFU_MISALIGN_CHECK_EN to add the sticky ADDR_MISALIGNED output.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_ADDRESS,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    input  logic        IMEM_BUSYWAIT,
    input  logic [31:0] IMEM_INSTRUCTION,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC_OUT,
    output logic [31:0] PC_PLUS4,
    output logic        INSTR_VALID
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic        ADDR_MISALIGNED
`endif
);

    logic [1:0]  state, state_n;
    logic        in_flight, in_flight_n;
    logic [31:0] hold_buf, pending;
    logic [31:0] pc, target, load_value;
    logic        pc_load, pc_inc, complete;
    logic        bubble, take_mem, take_buf, to_hold, pend_load;

    assign target   = word_align(BRANCH_ADDRESS);
    assign complete = IMEM_READ && !IMEM_BUSYWAIT;
    assign IMEM_ADDRESS = pc;
    assign PC_PLUS4 = PC_OUT + 32'd4;

    // Request drops combinationally with reset so memory sees no stale access.
    always_comb begin
        IMEM_READ = 1'b0;
        case (state)
            ST_FETCH: IMEM_READ = RESET && (!STALL || in_flight);
            ST_DRAIN: IMEM_READ = RESET;
            default:  IMEM_READ = 1'b0;
        endcase
    end

    always_comb begin
        state_n     = state;
        in_flight_n = 1'b0;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        load_value  = target;
        bubble      = 1'b0;
        take_mem    = 1'b0;
        take_buf    = 1'b0;
        to_hold     = 1'b0;
        pend_load   = 1'b0;
        case (state)
            ST_FETCH: begin
                if (BRANCH_TAKEN) begin
                    bubble = 1'b1;
                    if (IMEM_READ && IMEM_BUSYWAIT) begin
                        pend_load = 1'b1;
                        state_n   = ST_DRAIN;
                    end else begin
                        pc_load = 1'b1;
                    end
                end else if (complete) begin
                    if (STALL) begin
                        to_hold = 1'b1;
                        state_n = ST_HOLD;
                    end else begin
                        take_mem = 1'b1;
                        pc_inc   = 1'b1;
                    end
                end else begin
                    in_flight_n = IMEM_READ;
                end
            end
            ST_HOLD: begin
                if (BRANCH_TAKEN) begin
                    bubble  = 1'b1;
                    pc_load = 1'b1;
                    state_n = ST_FETCH;
                end else if (!STALL) begin
                    take_buf = 1'b1;
                    pc_inc   = 1'b1;
                    state_n  = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                bubble = BRANCH_TAKEN;
                if (complete) begin
                    pc_load    = 1'b1;
                    load_value = BRANCH_TAKEN ? target : pending;
                    state_n    = ST_FETCH;
                end else begin
                    pend_load = BRANCH_TAKEN;
                end
            end
            default: state_n = ST_FETCH;
        endcase
    end

    ifu_pc_reg u_pc_reg (
        .clk        (CLK),
        .rst_n      (RESET),
        .load       (pc_load),
        .inc        (pc_inc),
        .load_value (load_value),
        .pc         (pc)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= ST_FETCH;
            in_flight   <= 1'b0;
            hold_buf    <= 32'd0;
            pending     <= 32'd0;
            INSTRUCTION <= NOP_WORD;
            PC_OUT      <= RESET_PC;
            INSTR_VALID <= 1'b0;
        end else begin
            state     <= state_n;
            in_flight <= in_flight_n;
            if (to_hold) hold_buf <= IMEM_INSTRUCTION;
            if (pend_load) pending <= target;
            if (bubble) begin
                INSTRUCTION <= NOP_WORD;
                INSTR_VALID <= 1'b0;
            end else if (take_mem) begin
                INSTRUCTION <= IMEM_INSTRUCTION;
                PC_OUT      <= pc;
                INSTR_VALID <= 1'b1;
            end else if (take_buf) begin
                INSTRUCTION <= hold_buf;
                PC_OUT      <= pc;
                INSTR_VALID <= 1'b1;
            end
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ADDR_MISALIGNED <= 1'b0;
        end else if (BRANCH_TAKEN && (BRANCH_ADDRESS[1:0] != 2'b00)) begin
            ADDR_MISALIGNED <= 1'b1;
        end
    end
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^BRANCH_ADDRESS[1:0];
`endif

endmodule
